univ_shift_reg: RTL and testbench

Parametrised universal register that succeeds the single-bit D storage element. It provides WIDTH-bit storage with eight operating modes: hold, parallel load, logical shifts, rotates, arithmetic shift and synchronous clear. A shift counter with a done pulse lets the block serve as a serializer or deserializer for the d02 datapath exercises.

---
 rtl/usr_pkg.sv | 30 +++
 rtl/usr_next_val.sv | 33 +++
 rtl/univ_shift_reg.sv | 86 ++++++++
 tb/tb_univ_shift_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the mode encoding
// used by the datapath, the control flops and any bench driving the block.
// Port summary: none (package only).
package usr_pkg;

  // Operation select. The encoding is fixed because it is driven directly
  // from a 3-bit port.
  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101,
    ASR  = 3'b110,
    CLR  = 3'b111
  } mode_e;

  // Modes that move bits through the register and therefore advance the
  // shift counter.
  function automatic logic is_shift_mode(input mode_e m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
  endfunction

  // Modes whose serial output is the MSB (data leaves from the left end).
  function automatic logic is_left_mode(input mode_e m);
    return (m == SHL) || (m == ROL);
  endfunction

endpackage

// File: rtl/usr_next_val.sv
// Next-state datapath for the universal shift register: picks the value q
// takes on the next enabled edge. Purely combinational, zero latency, no
// flow control. Ports: q (current contents), d (parallel data), sin (serial
// in), mode (operation), nxt (next contents).
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  mode_e            mode,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = q;
    case (mode)
      HOLD:    nxt = q;
      LOAD:    nxt = d;
      SHL:     nxt = {q[WIDTH-2:0], sin};
      SHR:     nxt = {sin, q[WIDTH-1:1]};
      ROL:     nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:     nxt = {q[0], q[WIDTH-1:1]};
      // Sign bit is replicated; sin is deliberately not consulted.
      ASR:     nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      CLR:     nxt = '0;
      default: nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/ASR/clear with a
// saturating shift counter and a one-shot done pulse for SerDes use.
// Latency: q, cnt and done update one clock after the enabled edge; qn and
// sout are combinational from q. No backpressure: en=0 simply holds.
// Ports: clk, rst (async active-low), en, mode, d, sin -> q, qn, sout, cnt, done.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int               WIDTH   = 8,
  parameter  logic [WIDTH-1:0] RST_VAL = '0,
  localparam int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_r;
  logic             done_nxt;

  assign mode_sel = mode_e'(mode);

  usr_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .q    (q_r),
    .d    (d),
    .sin  (sin),
    .mode (mode_sel),
    .nxt  (q_nxt)
  );

  // Counter/done decode for an enabled edge. LOAD and CLR restart the count
  // and suppress any completion on the same edge. done fires only on the
  // WIDTH-1 -> WIDTH step, so it never repeats while saturated.
  always_comb begin
    cnt_nxt  = cnt_r;
    done_nxt = 1'b0;
    if ((mode_sel == LOAD) || (mode_sel == CLR)) begin
      cnt_nxt = '0;
    end else if (is_shift_mode(mode_sel)) begin
      if (cnt_r < CNT_MAX) begin
        cnt_nxt = cnt_r + CNT_W'(1);
      end
      done_nxt = (cnt_r == CNT_MAX - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= RST_VAL;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (en) begin
      q_r    <= q_nxt;
      cnt_r  <= cnt_nxt;
      done_r <= done_nxt;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign q    = q_r;
  assign qn   = ~q_r;
  assign cnt  = cnt_r;
  assign done = done_r;
  // Left-moving modes emit the MSB; everything else emits the LSB, so a
  // serializer can sample sout before the shifting edge.
  assign sout = is_left_mode(mode_sel) ? q_r[WIDTH-1] : q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: three instances (8-bit with non-zero
// reset value, 2-bit, 16-bit) share clock and controls; each scenario task
// drives stimulus and compares against hand-computed values.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic        sin;

  logic [7:0]  d8,  q8,  qn8;
  logic [3:0]  cnt8;
  logic        sout8, done8;
  logic [1:0]  d2,  q2,  qn2;
  logic [1:0]  cnt2;
  logic        sout2, done2;
  logic [15:0] d16, q16, qn16;
  logic [4:0]  cnt16;
  logic        sout16, done16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d8), .sin(sin),
    .q(q8), .qn(qn8), .sout(sout8), .cnt(cnt8), .done(done8));

  univ_shift_reg #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d2), .sin(sin),
    .q(q2), .qn(qn2), .sout(sout2), .cnt(cnt2), .done(done2));

  univ_shift_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d16), .sin(sin),
    .q(q16), .qn(qn16), .sout(sout16), .cnt(cnt16), .done(done16));

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = HOLD; sin = 1'b0;
    d8 = 8'h00; d2 = 2'b00; d16 = 16'h0000;
    #12;
    rst = 1'b1;
    step();
    en = 1'b1; mode = LOAD; d8 = 8'h11;
    step();
    n_checks++;
    if (q8 !== 8'h11) begin n_fail++; $display("FAIL reset_preload q8 got %h want 11", q8); end
    // Assert reset between edges: state must change without a clock.
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (q8 !== 8'hA5) begin n_fail++; $display("FAIL reset_async_q got %h want a5", q8); end
    n_checks++;
    if (qn8 !== 8'h5A) begin n_fail++; $display("FAIL reset_async_qn got %h want 5a", qn8); end
    n_checks++;
    if (cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_cnt_done got cnt=%0d done=%b want 0/0", cnt8, done8);
    end
    n_checks++;
    if (q16 !== 16'h0000 || q2 !== 2'b00) begin
      n_fail++; $display("FAIL reset_default_val got q16=%h q2=%b want 0/0", q16, q2);
    end
    @(posedge clk);
    #1 rst = 1'b1; mode = HOLD;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q8 !== 8'hA5) begin n_fail++; $display("FAIL reset_hold%0d got %h want a5", i, q8); end
    end
  endtask

  task automatic test_shl();
    logic [7:0] exp_q;
    mode = LOAD; d8 = 8'h81;
    step();
    n_checks++;
    if (q8 !== 8'h81 || cnt8 !== 4'd0) begin
      n_fail++; $display("FAIL shl_load got q=%h cnt=%0d want 81/0", q8, cnt8);
    end
    mode = SHL; sin = 1'b1;
    n_checks++;
    if (sout8 !== 1'b1) begin n_fail++; $display("FAIL shl_sout got %b want 1", sout8); end
    exp_q = 8'h81;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_q = {exp_q[6:0], 1'b1};
      n_checks++;
      if (q8 !== exp_q || cnt8 !== 4'(i) || done8 !== (i == 8)) begin
        n_fail++;
        $display("FAIL shl_edge%0d got q=%h cnt=%0d done=%b want %h/%0d/%b",
                 i, q8, cnt8, done8, exp_q, i, (i == 8));
      end
    end
    step();
    n_checks++;
    if (q8 !== 8'hFF || cnt8 !== 4'd8 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL shl_saturate got q=%h cnt=%0d done=%b want ff/8/0", q8, cnt8, done8);
    end
  endtask

  task automatic test_rotate();
    mode = LOAD; d8 = 8'h01;
    step();
    mode = ROR;
    #1;
    n_checks++;
    if (sout8 !== 1'b1) begin n_fail++; $display("FAIL ror_sout got %b want 1", sout8); end
    step();
    n_checks++;
    if (q8 !== 8'h80) begin n_fail++; $display("FAIL ror_q got %h want 80", q8); end
    mode = ROL;
    #1;
    n_checks++;
    if (sout8 !== 1'b1) begin n_fail++; $display("FAIL rol_sout got %b want 1", sout8); end
    step();
    step();
    n_checks++;
    if (q8 !== 8'h02 || sout8 !== 1'b0) begin
      n_fail++; $display("FAIL rol_q got q=%h sout=%b want 02/0", q8, sout8);
    end
  endtask

  task automatic test_asr();
    logic [7:0] exp_tab [3];
    exp_tab[0] = 8'hC8; exp_tab[1] = 8'hE4; exp_tab[2] = 8'hF2;
    mode = LOAD; d8 = 8'h90;
    step();
    mode = ASR;
    for (int i = 0; i < 3; i++) begin
      sin = i[0];
      step();
      n_checks++;
      if (q8 !== exp_tab[i]) begin n_fail++; $display("FAIL asr_edge%0d got %h want %h", i, q8, exp_tab[i]); end
    end
  endtask

  task automatic test_enable_collision();
    mode = LOAD; d8 = 8'h01;
    step();
    mode = SHL; sin = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (q8 !== 8'h80 || cnt8 !== 4'd7) begin
      n_fail++; $display("FAIL en_setup got q=%h cnt=%0d want 80/7", q8, cnt8);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (q8 !== 8'h80 || cnt8 !== 4'd7 || done8 !== 1'b0) begin
        n_fail++; $display("FAIL en_frozen%0d got q=%h cnt=%0d done=%b want 80/7/0", i, q8, cnt8, done8);
      end
    end
    en = 1'b1; mode = LOAD; d8 = 8'h3C;
    step();
    n_checks++;
    if (q8 !== 8'h3C || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL load_collision got q=%h cnt=%0d done=%b want 3c/0/0", q8, cnt8, done8);
    end
    mode = CLR;
    step();
    n_checks++;
    if (q8 !== 8'h00 || cnt8 !== 4'd0) begin
      n_fail++; $display("FAIL clr got q=%h cnt=%0d want 00/0", q8, cnt8);
    end
  endtask

  task automatic test_reset_mid_shift();
    mode = LOAD; d8 = 8'hF0;
    step();
    mode = SHR; sin = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (q8 !== 8'h0F || cnt8 !== 4'd4) begin
      n_fail++; $display("FAIL shr_setup got q=%h cnt=%0d want 0f/4", q8, cnt8);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (q8 !== 8'hA5 || cnt8 !== 4'd0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_shift got q=%h cnt=%0d done=%b want a5/0/0", q8, cnt8, done8);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_width_sweep();
    logic [1:0]  e2;
    logic [15:0] e16;
    mode = LOAD; d2 = 2'b01; d16 = 16'h8001;
    step();
    n_checks++;
    if (q2 !== 2'b01 || q16 !== 16'h8001 || cnt2 !== 2'd0 || cnt16 !== 5'd0) begin
      n_fail++; $display("FAIL sweep_load got q2=%b q16=%h cnt2=%0d cnt16=%0d", q2, q16, cnt2, cnt16);
    end
    mode = SHL; sin = 1'b1;
    e2 = 2'b01; e16 = 16'h8001;
    for (int i = 1; i <= 17; i++) begin
      step();
      e2  = {e2[0], 1'b1};
      e16 = {e16[14:0], 1'b1};
      n_checks++;
      if (q2 !== e2 || cnt2 !== 2'((i < 2) ? i : 2) || done2 !== (i == 2)) begin
        n_fail++;
        $display("FAIL w2_edge%0d got q=%b cnt=%0d done=%b want %b/%0d/%b",
                 i, q2, cnt2, done2, e2, (i < 2) ? i : 2, (i == 2));
      end
      n_checks++;
      if (q16 !== e16 || cnt16 !== 5'((i < 16) ? i : 16) || done16 !== (i == 16)) begin
        n_fail++;
        $display("FAIL w16_edge%0d got q=%h cnt=%0d done=%b want %h/%0d/%b",
                 i, q16, cnt16, done16, e16, (i < 16) ? i : 16, (i == 16));
      end
    end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_rotate();
    test_asr();
    test_enable_collision();
    test_reset_mid_shift();
    test_width_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
